// File: rtl/fx_alu_engine_pkg.sv
// Shared op codes, FSM state encodings and saturation helpers for the fixed-point ALU engine.
package fx_alu_pkg;

  localparam logic [2:0] OP_DIV = 3'd0;
  localparam logic [2:0] OP_MUL = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SQR = 3'd4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FIX   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Bit patterns of the signed saturation limits for a w-bit result (w <= 64).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fx_alu_engine_if.sv
// Request/result handshake bundle between the iteration sequencer, the ALU engine and the escape test.
interface fx_alu_engine_if #(
  parameter int W     = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     q;
  logic [W-1:0]     r;
  logic [TAG_W-1:0] out_tag;
  logic             ovf;
  logic             dz;
  logic             err;

  modport master (
    output in_valid, op, a, b, tag, out_ready,
    input  in_ready, out_valid, q, r, out_tag, ovf, dz, err
  );

  modport slave (
    input  in_valid, op, a, b, tag, out_ready,
    output in_ready, out_valid, q, r, out_tag, ovf, dz, err
  );
endinterface

// File: rtl/fx_alu_engine_shift_core.sv
// Shared shift register for unsigned magnitudes: right-shift/add multiply (W steps) or restoring divide (W+FRAC steps).
// One bit per step; o_last is high on the step that completes the operation.
module fx_shift_core #(
  parameter int W    = 32,
  parameter int FRAC = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_step,
  input  logic                i_div,
  input  logic [W-1:0]        i_ma,
  input  logic [W-1:0]        i_mb,
  output logic                o_last,
  output logic [2*W-1:0]      o_prod,
  output logic [W+FRAC-1:0]   o_quo,
  output logic [W-1:0]        o_rem
);
  localparam int N_DIV = W + FRAC;
  localparam int SR_W  = W + N_DIV;
  localparam int CW    = $clog2(N_DIV);

  logic [SR_W-1:0] r_sr;
  logic [W-1:0]    r_mb;
  logic [CW-1:0]   r_cnt;
  logic            r_div;

  logic [W:0]      w_msum;
  logic [W:0]      w_trial;
  logic            w_ge;
  logic [W-1:0]    w_nrem;

  // Multiply: {acc, multiplier} shifts right. Divide: {remainder, dividend/quotient} shifts left.
  assign w_msum  = {1'b0, r_sr[2*W-1:W]} + (r_sr[0] ? {1'b0, r_mb} : '0);
  assign w_trial = {r_sr[SR_W-1:N_DIV], r_sr[N_DIV-1]};
  assign w_ge    = w_trial >= {1'b0, r_mb};
  assign w_nrem  = w_ge ? W'(w_trial - {1'b0, r_mb}) : w_trial[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_mb  <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (i_load) begin
      r_mb  <= i_mb;
      r_div <= i_div;
      r_cnt <= i_div ? CW'(N_DIV - 1) : CW'(W - 1);
      r_sr  <= i_div ? (SR_W'(i_ma) << FRAC) : SR_W'(i_ma);
    end else if (i_step) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_div) r_sr <= {w_nrem, r_sr[N_DIV-2:0], w_ge};
      else       r_sr <= SR_W'({w_msum, r_sr[W-1:1]});
    end
  end

  assign o_last = (r_cnt == '0);
  assign o_prod = r_sr[2*W-1:0];
  assign o_quo  = r_sr[N_DIV-1:0];
  assign o_rem  = r_sr[SR_W-1:N_DIV];
endmodule

// File: rtl/fx_alu_engine.sv
// Iterative signed Q fixed-point ALU (DIV/MUL/SQR/ADD/SUB) with saturation; one request in flight at a time.
// Latency 2 (ADD/SUB/illegal/div-by-zero), W+2 (MUL/SQR), W+FRAC+2 (DIV); result held until out_ready.
module fx_alu_engine
  import fx_alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int FRAC  = 24,
  parameter int TAG_W = 8
) (
  input logic            clk,
  input logic            rst,
  fx_alu_engine_if.slave bus
);
  localparam int MW = 2 * W + FRAC;
  localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
  localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));

  logic [2:0]       r_state, r_op;
  logic [W-1:0]     r_a, r_b, r_q, r_r;
  logic [TAG_W-1:0] r_tag, r_out_tag;
  logic             r_out_valid, r_ovf, r_dz, r_err;

  logic             w_is_div, w_bz, w_long, w_neg, w_last;
  logic [W-1:0]     w_ma, w_mb_abs, w_mb, w_rem, w_q, w_r;
  logic [2*W-1:0]   w_prod;
  logic [W+FRAC-1:0] w_quo;
  logic [MW-1:0]    w_mag;
  logic [W:0]       w_sum;
  logic             w_ovf, w_dz, w_err;

  // Operands stay latched for the whole operation, so signs/magnitudes are derived combinationally.
  assign w_is_div = (r_op == OP_DIV);
  assign w_bz     = (r_b == '0);
  assign w_long   = (r_op == OP_MUL) || (r_op == OP_SQR) || (w_is_div && !w_bz);
  assign w_neg    = (r_op == OP_SQR) ? 1'b0 : (r_a[W-1] ^ r_b[W-1]);
  assign w_ma     = r_a[W-1] ? -r_a : r_a;
  assign w_mb_abs = r_b[W-1] ? -r_b : r_b;
  assign w_mb     = (r_op == OP_SQR) ? w_ma : w_mb_abs;

  fx_shift_core #(.W(W), .FRAC(FRAC)) u_core (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_state == ST_SETUP && w_long),
    .i_step (r_state == ST_RUN),
    .i_div  (w_is_div),
    .i_ma   (w_ma),
    .i_mb   (w_mb),
    .o_last (w_last),
    .o_prod (w_prod),
    .o_quo  (w_quo),
    .o_rem  (w_rem)
  );

  always_comb begin
    w_q   = '0;
    w_r   = '0;
    w_ovf = 1'b0;
    w_dz  = 1'b0;
    w_err = 1'b0;
    w_mag = w_is_div ? MW'(w_quo) : MW'(w_prod >> FRAC);
    w_sum = (r_op == OP_SUB) ? ({r_a[W-1], r_a} - {r_b[W-1], r_b})
                             : ({r_a[W-1], r_a} + {r_b[W-1], r_b});
    case (r_op)
      OP_ADD, OP_SUB: begin
        if (w_sum[W] != w_sum[W-1]) begin
          w_ovf = 1'b1;
          w_q   = w_sum[W] ? SAT_MIN : SAT_MAX;
        end else begin
          w_q = w_sum[W-1:0];
        end
      end
      OP_MUL, OP_SQR, OP_DIV: begin
        if (w_is_div && w_bz) begin
          w_dz = 1'b1;
          w_q  = r_a[W-1] ? SAT_MIN : SAT_MAX;
        end else begin
          // Negative side reaches one step further than positive before clamping.
          if (w_neg && w_mag > MW'(SAT_MIN)) begin
            w_ovf = 1'b1;
            w_q   = SAT_MIN;
          end else if (!w_neg && w_mag > MW'(SAT_MAX)) begin
            w_ovf = 1'b1;
            w_q   = SAT_MAX;
          end else begin
            w_q = w_neg ? -w_mag[W-1:0] : w_mag[W-1:0];
          end
          if (w_is_div) w_r = r_a[W-1] ? -w_rem : w_rem;
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_tag       <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_out_tag   <= '0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.in_valid) begin
          r_op    <= bus.op;
          r_a     <= bus.a;
          r_b     <= bus.b;
          r_tag   <= bus.tag;
          r_state <= ST_SETUP;
        end
        ST_SETUP: r_state <= w_long ? ST_RUN : ST_FIX;
        ST_RUN:   if (w_last) r_state <= ST_FIX;
        ST_FIX: begin
          r_q         <= w_q;
          r_r         <= w_r;
          r_out_tag   <= r_tag;
          r_ovf       <= w_ovf;
          r_dz        <= w_dz;
          r_err       <= w_err;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.q         = r_q;
  assign bus.r         = r_r;
  assign bus.out_tag   = r_out_tag;
  assign bus.ovf       = r_ovf;
  assign bus.dz        = r_dz;
  assign bus.err       = r_err;
endmodule
